// File: rtl/fp_normalize_pkg.sv
// Package fp: shared widths and helpers for the floating-point normalize stage.
//   MSB/EMSB/FMSB : IEEE single-precision field positions
//   NMW           : width of the unnormalized significand fed to fp_normalize
//   LZW           : width of a leading-zero count over NMW-1 bits
//   EXW           : signed working width for exponent arithmetic
//   EXP_INF       : all-ones biased exponent (infinity / NaN)
package fp;

  localparam int MSB  = 31;
  localparam int EMSB = 7;
  localparam int FMSB = 22;
  localparam int NMW  = 2*FMSB + 4;
  localparam int LZW  = $clog2(NMW);
  // Signed and one bit above x_i+1, so the carry increment of the largest
  // x_i still compares correctly against the overflow threshold.
  localparam int EXW  = EMSB + 4;
  localparam int OW   = MSB + 4;

  localparam logic [EMSB:0] EXP_INF = {(EMSB+1){1'b1}};

  // Shift applied to the significand in the second pipeline stage.
  typedef enum logic [1:0] {
    SH_NONE  = 2'd0,
    SH_RIGHT = 2'd1,
    SH_LEFT  = 2'd2
  } shift_dir_e;

  // Infinity/NaN input: low exponent bits all ones, overflow bit clear.
  function automatic logic is_special(input logic [EMSB+1:0] x);
    return (x[EMSB+1] == 1'b0) && (x[EMSB:0] == EXP_INF);
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter.
//   din [W-1:0]  : vector to scan, MSB first
//   cnt [OW-1:0] : number of zeros above the highest set bit (W when din==0)
module fp_lzc #(
  parameter int W  = 47,
  parameter int OW = 6
) (
  input  logic [W-1:0]  din,
  output logic [OW-1:0] cnt
);

  // Scan upward so the highest set bit is written last and wins.
  always_comb begin
    cnt = OW'(W);
    for (int i = 0; i < W; i++) begin
      cnt = din[i] ? OW'(W - 1 - i) : cnt;
    end
  end

endmodule

// File: rtl/fp_normalize.sv
// fp_normalize: three-stage normalization ahead of the rounding unit.
//   clk, rst (async, active high), ce (stalls every register including valids)
//   vld_i, s_i, x_i [EMSB+1:0], m_i [NMW-1:0] : unnormalized input sample
//   vld_o                                      : vld_i delayed three ce cycles
//   o [MSB+3:0] : {sign, exponent[EMSB:0], significand[FMSB+2:0], sticky}
// Stage 1 registers the inputs, carry flag and leading-zero count; stage 2
// selects and applies the shift and forms the provisional exponent; stage 3
// reduces sticky, applies zero/overflow/special selection and packs o.
module fp_normalize
  import fp::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            vld_i,
  input  logic            s_i,
  input  logic [EMSB+1:0] x_i,
  input  logic [NMW-1:0]  m_i,
  output logic            vld_o,
  output logic [MSB+3:0]  o
);

  localparam logic [EMSB+1:0]      X_ZERO  = {(EMSB+2){1'b0}};
  localparam logic [EMSB+1:0]      X_ONE   = {{(EMSB+1){1'b0}}, 1'b1};
  localparam logic signed [EXW-1:0] EXP_OVF = EXW'(EXP_INF);

  // ---------------- stage 1 ----------------
  logic            vld1_r;
  logic            s1_r;
  logic            carry1_r;
  logic [EMSB+1:0] x1_r;
  logic [NMW-1:0]  m1_r;
  logic [LZW-1:0]  lz1_r;
  logic [LZW-1:0]  lz_s;

  fp_lzc #(.W(NMW-1), .OW(LZW)) u_lzc (
    .din (m_i[NMW-2:0]),
    .cnt (lz_s)
  );

  // Stage 1 register: raw sample, carry-out flag and leading-zero count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld1_r   <= 1'b0;
      s1_r     <= 1'b0;
      carry1_r <= 1'b0;
      x1_r     <= X_ZERO;
      m1_r     <= {NMW{1'b0}};
      lz1_r    <= {LZW{1'b0}};
    end else if (ce) begin
      vld1_r   <= vld_i;
      s1_r     <= s_i;
      carry1_r <= m_i[NMW-1];
      x1_r     <= x_i;
      m1_r     <= m_i;
      lz1_r    <= lz_s;
    end
  end

  // ---------------- stage 2 ----------------
  shift_dir_e             dir_s;
  logic [LZW-1:0]         sh_amt_s;
  logic signed [EXW-1:0]  exp_s;
  logic                   special_s;
  logic                   zero_s;
  logic [NMW-2:0]         shm_s;
  logic                   rloss_s;

  // Shift direction/amount and provisional exponent for each input class.
  always_comb begin
    dir_s     = SH_NONE;
    sh_amt_s  = {LZW{1'b0}};
    exp_s     = {EXW{1'b0}};
    special_s = is_special(x1_r);
    // An all-zero significand is the only non-carry case with lz = NMW-1.
    zero_s    = ~carry1_r & (lz1_r == LZW'(NMW-1));
    if (special_s) begin
      dir_s = SH_NONE;
      exp_s = EXW'(EXP_INF);
    end else if (carry1_r) begin
      dir_s = SH_RIGHT;
      exp_s = EXW'(x1_r) + EXW'(X_ONE);
    end else if (x1_r == X_ZERO) begin
      dir_s = SH_NONE;
      exp_s = {EXW{1'b0}};
    end else if (EXW'(x1_r) > EXW'(lz1_r)) begin
      dir_s    = SH_LEFT;
      sh_amt_s = lz1_r;
      exp_s    = EXW'(x1_r) - EXW'(lz1_r);
    end else begin
      // Denormal: shift only as far as the minimum exponent allows.
      dir_s    = SH_LEFT;
      sh_amt_s = LZW'(x1_r - X_ONE);
      exp_s    = {EXW{1'b0}};
    end
  end

  // Barrel shift into the NMW-1 bit field whose top bit is the leading-one slot.
  always_comb begin
    shm_s   = m1_r[NMW-2:0];
    rloss_s = 1'b0;
    case (dir_s)
      SH_RIGHT: begin
        shm_s   = m1_r[NMW-1:1];
        rloss_s = m1_r[0];
      end
      SH_LEFT:  shm_s = m1_r[NMW-2:0] << sh_amt_s;
      SH_NONE:  shm_s = m1_r[NMW-2:0];
      default:  shm_s = m1_r[NMW-2:0];
    endcase
  end

  logic                  vld2_r;
  logic                  s2_r;
  logic                  special2_r;
  logic                  zero2_r;
  logic                  rloss2_r;
  logic signed [EXW-1:0] exp2_r;
  logic [NMW-2:0]        shm2_r;

  // Stage 2 register: shifted significand, exponent and class flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld2_r     <= 1'b0;
      s2_r       <= 1'b0;
      special2_r <= 1'b0;
      zero2_r    <= 1'b0;
      rloss2_r   <= 1'b0;
      exp2_r     <= {EXW{1'b0}};
      shm2_r     <= {(NMW-1){1'b0}};
    end else if (ce) begin
      vld2_r     <= vld1_r;
      s2_r       <= s1_r;
      special2_r <= special_s;
      zero2_r    <= zero_s;
      rloss2_r   <= rloss_s;
      exp2_r     <= exp_s;
      shm2_r     <= shm_s;
    end
  end

  // ---------------- stage 3 ----------------
  logic           sticky_s;
  logic           ovf_s;
  logic [OW-1:0]  o_s;

  // Sticky reduction and final result selection.
  always_comb begin
    sticky_s = rloss2_r | (|shm2_r[NMW-FMSB-5:0]);
    ovf_s    = (exp2_r >= EXP_OVF);
    if (special2_r) begin
      o_s = {s2_r, EXP_INF, shm2_r[NMW-2 -: FMSB+3], 1'b0};
    end else if (zero2_r) begin
      o_s = {s2_r, {(OW-1){1'b0}}};
    end else if (ovf_s) begin
      o_s = {s2_r, EXP_INF, {(FMSB+4){1'b0}}};
    end else begin
      o_s = {s2_r, exp2_r[EMSB:0], shm2_r[NMW-2 -: FMSB+3], sticky_s};
    end
  end

  // Output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_o <= 1'b0;
      o     <= {OW{1'b0}};
    end else if (ce) begin
      vld_o <= vld2_r;
      o     <= o_s;
    end
  end

endmodule
